fetch_ctrl: RTL and testbench

Sequencer for the fetch datapath: PC register, PC+4 incrementer, 2:1 next-PC mux and synchronous instruction memory with 1-cycle read latency. It drives the PC-mux select, PC load enable and memory read enable. It also tags the returned instruction with a valid bit and its PC. It handles boot delay, decode back-pressure (stall), control-flow redirect and halt/resume, and sits between the fetch datapath and decode.

---
 rtl/fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: boot delay, stall, redirect, halt/resume.
// Optional redirect alignment check under FETCH_MISALIGN_CHK_EN.
module fetch_ctrl #(
  parameter int XLEN       = 32,
  parameter int BOOT_DELAY = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            pc_sel_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            pc_en_o,
  output logic            imem_en_o,
  output logic            valid_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            halted_o
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic            misalign_o
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] fpc_q, fpc_d;

  logic in_boot, in_halt, active;
  logic redir_bad;
  logic ev_take, ev_park, ev_halt;
  logic ev_stall, ev_issue;
  logic pc_sel, pc_en, imem_en;

  assign in_boot = (state_q == BOOT);
  assign in_halt = (state_q == HALT);
  assign active  = (state_q == RUN)
                 | (state_q == STALL);

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_bad = redirect_i & ~in_boot
                   & (|redirect_pc_i[1:0]);
`else
  assign redir_bad = 1'b0;
`endif

  // One-hot event decode; redirect outranks halt outranks stall.
  assign ev_take  = redirect_i & ~in_boot
                  & ~redir_bad;
  assign ev_park  = in_halt & ~redirect_i;
  assign ev_halt  = active & ~redirect_i
                  & halt_i;
  assign ev_stall = active & ~redirect_i
                  & ~halt_i & stall_i;
  assign ev_issue = active & ~redirect_i
                  & ~halt_i & ~stall_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fpc_q   <= fpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    fpc_d   = fpc_q;
    unique case (1'b1)
      in_boot: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == BOOT_LAST) state_d = RUN;
      end
      ev_take: begin
        valid_d = 1'b0;
        state_d = RUN;
      end
      redir_bad: begin
        valid_d = 1'b0;
        state_d = HALT;
      end
      ev_park: ;
      ev_halt: begin
        valid_d = 1'b0;
        state_d = HALT;
      end
      ev_stall: state_d = STALL;
      ev_issue: begin
        valid_d = 1'b1;
        fpc_d   = pc_i;
        state_d = RUN;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_sel  = 1'b0;
    pc_en   = 1'b0;
    imem_en = 1'b0;
    unique case (1'b1)
      ev_take: begin
        pc_sel  = 1'b1;
        pc_en   = 1'b1;
        imem_en = 1'b1;
      end
      ev_issue: begin
        pc_en   = 1'b1;
        imem_en = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if (redir_bad)    mis_d = 1'b1;
    else if (ev_take) mis_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end

  assign misalign_o = mis_q;
`endif

  assign pc_sel_o   = rst & pc_sel;
  assign pc_en_o    = rst & pc_en;
  assign imem_en_o  = rst & imem_en;
  assign pc_next_o  = redirect_pc_i;
  assign valid_o    = valid_q;
  assign fetch_pc_o = fpc_q;
  assign halted_o   = in_halt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven bench for fetch_ctrl with a fetch-PC scoreboard.
// Models the PC register; checks misalign_o if FETCH_MISALIGN_CHK_EN.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        halt_i = 1'b0;
  logic        pc_sel_o, pc_en_o, imem_en_o;
  logic        valid_o, halted_o;
  logic [31:0] pc_next_o, fetch_pc_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  fetch_ctrl #(.XLEN(32), .BOOT_DELAY(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .pc_sel_o      (pc_sel_o),
    .pc_next_o     (pc_next_o),
    .pc_en_o       (pc_en_o),
    .imem_en_o     (imem_en_o),
    .valid_o       (valid_o),
    .fetch_pc_o    (fetch_pc_o),
    .halted_o      (halted_o)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  // Fetch datapath: PC register fed by PC+4 / redirect mux.
  always @(posedge clk or negedge rst) begin
    if (!rst)         pc <= '0;
    else if (pc_en_o) pc <= pc_sel_o ? pc_next_o : pc + 32'd4;
  end

  typedef struct packed {
    logic        s, r, h;
    logic [31:0] rpc;
    logic        en, sel, v, hl;
    logic [31:0] fpc;
    logic        iss;
    logic [31:0] ipc;
    logic        mis;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sbq[$];
  logic        prev_iss = 1'b0;
  vec_t        tbl[$];
  vec_t        hand[$];

  function automatic vec_t V(
    input logic s, r, h, input logic [31:0] rpc,
    input logic en, sel, v, hl, input logic [31:0] fpc,
    input logic iss, input logic [31:0] ipc,
    input logic mis);
    vec_t t;
    t = '{s, r, h, rpc, en, sel, v, hl, fpc, iss, ipc, mis};
    return t;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t t);
    logic [31:0] e;
    @(negedge clk);
    stall_i = t.s;
    redirect_i = t.r;
    halt_i = t.h;
    redirect_pc_i = t.rpc;
    #1;
    chk("pc_en", pc_en_o, t.en);
    chk("imem_en", imem_en_o, t.en);
    chk("pc_sel", pc_sel_o, t.sel);
    chk("valid", valid_o, t.v);
    chk("halted", halted_o, t.hl);
    chk("pc_next", pc_next_o, t.rpc);
    if (t.v) chk("fetch_pc", fetch_pc_o, t.fpc);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("misalign", misalign_o, t.mis);
`endif
    if (t.iss) begin
      chk("issue_pc", pc, t.ipc);
      sbq.push_back(t.ipc);
    end
    if (prev_iss) begin
      if (sbq.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_valid", valid_o, 32'd1);
        chk("sb_pc", fetch_pc_o, e);
      end
    end
    prev_iss = pc_en_o & imem_en_o & ~pc_sel_o;
  endtask

  initial begin
    // Main run: s r h rpc | en sel v hl fpc | iss ipc | mis
    tbl.push_back(V(0,0,0,0,     0,0,0,0,0, 0,0,0));
    tbl.push_back(V(0,1,0,'h500, 0,0,0,0,0, 0,0,0));
    tbl.push_back(V(0,0,1,0,     0,0,0,0,0, 0,0,0));
    tbl.push_back(V(1,0,0,0,     0,0,0,0,0, 0,0,0));
    tbl.push_back(V(0,0,0,0, 1,0,0,0,0,    1,'h0,0));
    tbl.push_back(V(0,0,0,0, 1,0,1,0,'h0,  1,'h4,0));
    tbl.push_back(V(0,0,0,0, 1,0,1,0,'h4,  1,'h8,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(V(1,0,0,0, 0,0,1,0,'h8, 0,0,0));
    tbl.push_back(V(0,0,0,0, 1,0,1,0,'h8,  1,'hC,0));
    tbl.push_back(V(0,0,0,0, 1,0,1,0,'hC,  1,'h10,0));
    tbl.push_back(V(0,1,0,'h100, 1,1,1,0,'h10, 0,0,0));
    tbl.push_back(V(0,0,0,0, 1,0,0,0,0,    1,'h100,0));
    tbl.push_back(V(0,0,0,0, 1,0,1,0,'h100, 1,'h104,0));
    tbl.push_back(V(1,1,0,'h200, 1,1,1,0,'h104, 0,0,0));
    tbl.push_back(V(1,0,0,0, 0,0,0,0,0,    0,0,0));
    tbl.push_back(V(0,0,0,0, 1,0,0,0,0,    1,'h200,0));
    tbl.push_back(V(0,0,0,0, 1,0,1,0,'h200, 1,'h204,0));
    tbl.push_back(V(0,1,0,'h40, 1,1,1,0,'h204, 0,0,0));
    tbl.push_back(V(0,0,0,0, 1,0,0,0,0,    1,'h40,0));
    tbl.push_back(V(0,0,1,0, 0,0,1,0,'h40, 0,0,0));
    tbl.push_back(V(0,0,0,0, 0,0,0,1,0,    0,0,0));
    tbl.push_back(V(0,0,1,0, 0,0,0,1,0,    0,0,0));
    tbl.push_back(V(1,0,0,0, 0,0,0,1,0,    0,0,0));
    for (int i = 0; i < 7; i++)
      tbl.push_back(V(0,0,0,0, 0,0,0,1,0, 0,0,0));
    tbl.push_back(V(0,1,0,'h80, 1,1,0,1,0,  0,0,0));
    tbl.push_back(V(0,0,0,0, 1,0,0,0,0,    1,'h80,0));
    tbl.push_back(V(0,0,0,0, 1,0,1,0,'h80, 1,'h84,0));
    tbl.push_back(V(1,0,1,0, 0,0,1,0,'h84, 0,0,0));
    tbl.push_back(V(0,0,0,0, 0,0,0,1,0,    0,0,0));
    tbl.push_back(V(0,1,1,'hFFFF_FFF8, 1,1,0,1,0, 0,0,0));
    tbl.push_back(V(0,0,0,0, 1,0,0,0,0, 1,'hFFFF_FFF8,0));
    tbl.push_back(V(0,0,0,0, 1,0,1,0,'hFFFF_FFF8,
                    1,'hFFFF_FFFC,0));
    tbl.push_back(V(0,0,0,0, 1,0,1,0,'hFFFF_FFFC, 1,'h0,0));
    tbl.push_back(V(1,0,0,0, 0,0,1,0,'h0, 0,0,0));
    tbl.push_back(V(1,0,0,0, 0,0,1,0,'h0, 0,0,0));

    // After mid-stream reset: full boot delay again.
    for (int i = 0; i < 4; i++)
      hand.push_back(V(0,0,0,0, 0,0,0,0,0, 0,0,0));
    hand.push_back(V(0,0,0,0, 1,0,0,0,0,   1,'h0,0));
    hand.push_back(V(0,0,0,0, 1,0,1,0,'h0, 1,'h4,0));
`ifdef FETCH_MISALIGN_CHK_EN
    hand.push_back(V(0,1,0,'h102, 0,0,1,0,'h4, 0,0,0));
    hand.push_back(V(0,0,0,0, 0,0,0,1,0,      0,0,1));
    hand.push_back(V(0,1,0,'h104, 1,1,0,1,0,  0,0,1));
    hand.push_back(V(0,0,0,0, 1,0,0,0,0,   1,'h104,0));
    hand.push_back(V(0,0,0,0, 1,0,1,0,'h104, 1,'h108,0));
    hand.push_back(V(1,0,0,0, 0,0,1,0,'h108, 0,0,0));
`else
    hand.push_back(V(1,0,0,0, 0,0,1,0,'h4, 0,0,0));
`endif

    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_fetch_pc", fetch_pc_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_pc_en", pc_en_o, 0);
    chk("rst_imem_en", imem_en_o, 0);
    chk("rst_pc_sel", pc_sel_o, 0);
    @(posedge clk);
    #2 rst = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);
    chk("sb_drained", sbq.size(), 0);

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    stall_i = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_fetch_pc", fetch_pc_o, 0);
    chk("mid_rst_halted", halted_o, 0);
    chk("mid_rst_pc_en", pc_en_o, 0);
    chk("mid_rst_imem_en", imem_en_o, 0);
    chk("mid_rst_pc", pc, 0);
    sbq.delete();
    prev_iss = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;

    foreach (hand[i]) apply(hand[i]);
    chk("sb_drained_end", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
